// File: rtl/seq_mult_hs_if.sv
// Handshake bundle for the sequential multiplier: operand request channel
// (in_*), product response channel (out_*/p) and a busy status flag.
interface seq_mult_hs_if #(
  parameter int WIDTH = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               signed_en;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] p;
  logic               busy;

  // producer/consumer side
  modport master (
    output in_valid, a, b, signed_en, out_ready,
    input  in_ready, out_valid, p, busy
  );

  // multiplier side
  modport slave (
    input  in_valid, a, b, signed_en, out_ready,
    output in_ready, out_valid, p, busy
  );
endinterface

// File: rtl/seq_mult_hs.sv
// Sequential shift-add multiplier, one partial product per clock.
// Operands are reduced to magnitudes on accept, multiplied unsigned over
// WIDTH cycles, and the sign is re-applied when the product is registered.
module seq_mult_hs #(
  parameter int WIDTH = 8
) (
  input logic         clk,
  input logic         rst_n,
  seq_mult_hs_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int PW    = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  // latched operation: unsigned magnitudes plus the sign of the result
  typedef struct packed {
    logic [WIDTH-1:0] ma;
    logic [WIDTH-1:0] mb;
    logic             neg;
  } op_t;

  state_t           state, state_nxt;
  op_t              op;
  logic [PW-1:0]    acc, acc_nxt, p_q;
  logic [CNT_W-1:0] cnt;
  logic             init_done;
  logic             in_rdy, out_vld, busy_o;
  logic             accept, last;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic se);
    // -2^(WIDTH-1) negates to itself, which read unsigned is the right magnitude
    return (se && x[WIDTH-1]) ? -x : x;
  endfunction

  assign accept  = bus.in_valid && in_rdy;
  assign last    = (state == BUSY) && (cnt == CNT_W'(WIDTH - 1));
  assign acc_nxt = op.mb[0] ? acc + (PW'(op.ma) << cnt) : acc;

  // in_ready stays low through reset and rises on the first clock after release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) init_done <= 1'b0;
    else        init_done <= 1'b1;
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)                      state_nxt = BUSY;
      BUSY:    if (last)                        state_nxt = DONE;
      DONE:    if (out_vld && bus.out_ready)    state_nxt = IDLE;
      default:                                  state_nxt = IDLE;
    endcase
  end

  // handshake/status outputs decoded from state
  always_comb begin
    in_rdy  = 1'b0;
    out_vld = 1'b0;
    busy_o  = 1'b0;
    case (state)
      IDLE:    in_rdy  = init_done;
      BUSY:    busy_o  = 1'b1;
      DONE:    begin out_vld = 1'b1; busy_o = 1'b1; end
      default: ;
    endcase
  end

  // datapath: latch on accept, one shift-add per BUSY cycle, sign fixup on exit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op  <= '0;
      acc <= '0;
      cnt <= '0;
      p_q <= '0;
    end else if (accept) begin
      op.ma  <= mag(bus.a, bus.signed_en);
      op.mb  <= mag(bus.b, bus.signed_en);
      op.neg <= bus.signed_en & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
      acc    <= '0;
      cnt    <= '0;
    end else if (state == BUSY) begin
      acc   <= acc_nxt;
      op.mb <= op.mb >> 1;
      cnt   <= cnt + CNT_W'(1);
      if (last) p_q <= op.neg ? -acc_nxt : acc_nxt;
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = out_vld;
  assign bus.busy      = busy_o;
  assign bus.p         = p_q;
endmodule

// File: tb/tb_seq_mult_hs.sv
// Bench for seq_mult_hs (WIDTH=8): directed corner cases with literal
// expectations, then randomized traffic against a queue-based product model.
module tb_seq_mult_hs;
  localparam int W  = 8;
  localparam int PW = 2 * W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seq_mult_hs_if #(.WIDTH(W)) bus();
  seq_mult_hs #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_acc = 0;
  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] got_q[$];
  int            acc_cyc[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // reference product from plain integer arithmetic
  function automatic logic [PW-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic se);
    longint sx, sy;
    sx = se ? longint'($signed(x)) : longint'(x);
    sy = se ? longint'($signed(y)) : longint'(y);
    return PW'(sx * sy);
  endfunction

  function automatic logic [W-1:0] pick();
    logic [W-1:0] v;
    case ($urandom_range(0, 7))
      0:       v = '0;
      1:       v = 8'h80;
      2:       v = 8'hFF;
      3:       v = 8'h7F;
      default: v = W'($urandom);
    endcase
    return v;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard: inputs are stable at the falling edge, so handshakes decided
  // here are the ones the next rising edge will complete
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_p", bus.p, 0);
      chk("rst_in_ready", bus.in_ready, 0);
      chk("rst_busy", bus.busy, 0);
    end else begin
      if (bus.out_valid) begin
        if (exp_q.size() == 0) chk("unexpected_out_valid", 1, 0);
        else                   chk("sb_p", bus.p, exp_q[0]);
        chk("busy_with_valid", bus.busy, 1);
      end
      if (bus.busy) chk("in_ready_while_busy", bus.in_ready, 0);
      if (bus.out_valid && bus.out_ready && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        got_q.push_back(bus.p);
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(ref_mul(bus.a, bus.b, bus.signed_en));
        acc_cyc.push_back(cyc);
        n_acc++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one op from IDLE with out_ready high: operands presented in the cycle
  // before the capturing edge, product valid W+1 edges later
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic se,
                        input logic [PW-1:0] want, input string name);
    int e;
    bus.a = x; bus.b = y; bus.signed_en = se;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    tick();
    e = 1;
    bus.in_valid = 1'b0;
    while (!bus.out_valid && e < 40) begin
      tick();
      e++;
    end
    chk({name, "_latency"}, e, W + 1);
    @(negedge clk);
    chk({name, "_p"}, bus.p, want);
    tick();
  endtask

  initial begin
    logic [PW-1:0] p0;
    logic [W-1:0]  ta[3];
    logic [W-1:0]  tb_[3];
    logic          tse[3];
    logic [PW-1:0] twant[3];
    int            e, n0, guard, start;

    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0;
    bus.signed_en = 1'b0; bus.out_ready = 1'b0;

    // reset state, then in_ready only after the first clock past release
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    #1 chk("in_ready_before_first_clk", bus.in_ready, 0);
    tick();
    chk("in_ready_after_release", bus.in_ready, 1);
    chk("idle_busy", bus.busy, 0);

    // directed values
    run_op(8'd255, 8'd255, 1'b0, 16'hFE01, "u_max");
    run_op(8'hFD,  8'h05,  1'b1, 16'hFFF1, "s_m3x5");
    run_op(8'h80,  8'h80,  1'b1, 16'h4000, "s_min_sq");
    run_op(8'h80,  8'h80,  1'b0, 16'h4000, "u_80sq");
    run_op(8'h7F,  8'h80,  1'b1, 16'hC080, "s_max_min");
    run_op(8'h00,  8'hAB,  1'b1, 16'h0000, "zero");

    // backpressure: result held, new operands ignored
    bus.a = 8'd12; bus.b = 8'd11; bus.signed_en = 1'b0;
    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    e = 1;
    while (!bus.out_valid && e < 40) begin
      tick();
      e++;
    end
    chk("bp_latency", e, W + 1);
    p0 = bus.p;
    chk("bp_p", p0, 16'd132);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1; bus.a = 8'd3; bus.b = 8'd3;
      @(negedge clk);
      chk("bp_p_stable", bus.p, p0);
      chk("bp_out_valid", bus.out_valid, 1);
      chk("bp_in_ready", bus.in_ready, 0);
      tick();
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    tick();
    chk("bp_release_valid", bus.out_valid, 0);
    chk("bp_release_ready", bus.in_ready, 1);
    chk("bp_release_busy", bus.busy, 0);

    // back-to-back with in_valid held high
    ta[0] = 8'd3;   tb_[0] = 8'd4;   tse[0] = 1'b0; twant[0] = 16'd12;
    ta[1] = 8'hFF;  tb_[1] = 8'h02;  tse[1] = 1'b1; twant[1] = 16'hFFFE;
    ta[2] = 8'd100; tb_[2] = 8'd200; tse[2] = 1'b0; twant[2] = 16'h4E20;
    got_q.delete();
    acc_cyc.delete();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.a = ta[i]; bus.b = tb_[i]; bus.signed_en = tse[i]; bus.in_valid = 1'b1;
      n0 = acc_cyc.size();
      guard = 0;
      while (acc_cyc.size() == n0 && guard < 40) begin
        tick();
        guard++;
      end
    end
    bus.in_valid = 1'b0;
    guard = 0;
    while (got_q.size() < 3 && guard < 40) begin
      tick();
      guard++;
    end
    chk("b2b_count", got_q.size(), 3);
    for (int i = 0; i < 3; i++)
      if (i < got_q.size()) chk("b2b_p", got_q[i], twant[i]);
    chk("b2b_accepts", acc_cyc.size(), 3);
    if (acc_cyc.size() == 3) begin
      chk("b2b_spacing01", acc_cyc[1] - acc_cyc[0], W + 2);
      chk("b2b_spacing12", acc_cyc[2] - acc_cyc[1], W + 2);
    end

    // reset in the middle of an operation
    bus.a = 8'd200; bus.b = 8'd100; bus.signed_en = 1'b0;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (4) tick();
    chk("midop_busy_before", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    chk("midop_out_valid", bus.out_valid, 0);
    chk("midop_p", bus.p, 0);
    chk("midop_busy", bus.busy, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    tick();
    run_op(8'd7, 8'd6, 1'b0, 16'd42, "after_rst");

    // randomized traffic with stalls on both sides
    start = n_acc;
    guard = 0;
    while ((n_acc - start) < 2000 && guard < 60000) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.a         = pick();
      bus.b         = pick();
      bus.signed_en = 1'($urandom_range(0, 1));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      tick();
      guard++;
    end
    chk("rand_ops_done", ((n_acc - start) >= 2000), 1);
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      tick();
      guard++;
    end
    chk("rand_drained", exp_q.size(), 0);
    tick();
    chk("final_idle", bus.in_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
